// File: rtl/sim_pkg.sv
// Shared types, scene table and activity fold for the simulation run controller.
// Coordinate c of a scene vector belongs to body c/DIMENSIONS, axis c%DIMENSIONS (0 = x, 1 = y).
package sim_pkg;
    localparam int SPRITES    = 2;
    localparam int DIMENSIONS = 2;
    localparam int WIDTH      = 32;
    localparam int NCOORD     = SPRITES * DIMENSIONS;
    localparam int ACT_W      = 12;
    localparam int RADIUS_W   = 7;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_PAUSED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    typedef logic [WIDTH-1:0]    coord_t;
    typedef logic [WIDTH/2-1:0]  mass_t;
    typedef logic [RADIUS_W-1:0] radius_t;

    typedef struct packed {
        coord_t  [NCOORD-1:0]  locations;
        coord_t  [NCOORD-1:0]  velos;
        mass_t   [SPRITES-1:0] masses;
        radius_t [SPRITES-1:0] radii;
    } scene_t;

    function automatic scene_t scene_rom(input logic [7:0] idx);
        scene_t s;
        s = '0;
        case (idx)
            8'd1: begin
                s.locations[1] = 32'h0080_0000;
                s.locations[3] = 32'hff80_0000;
                s.velos[0]     = 32'h0001_0000;
                s.velos[2]     = 32'hffff_0000;
                s.masses[0]    = 16'h0200;
                s.masses[1]    = 16'h0200;
                s.radii[0]     = 7'd10;
                s.radii[1]     = 7'd10;
            end
            8'd2: begin
                s.locations[0] = 32'hffc0_0000;
                s.locations[2] = 32'h0040_0000;
                s.velos[0]     = 32'h0002_0000;
                s.masses[0]    = 16'h0800;
                s.masses[1]    = 16'h0100;
                s.radii[0]     = 7'd20;
                s.radii[1]     = 7'd6;
            end
            8'd3: begin
                s.locations[0] = 32'h0064_8000;
                s.locations[1] = 32'h0032_4000;
                s.locations[2] = 32'hff9b_8000;
                s.locations[3] = 32'hffcd_c000;
                s.velos[1]     = 32'hffff_8000;
                s.velos[3]     = 32'h0000_8000;
                s.masses[0]    = 16'h0300;
                s.masses[1]    = 16'h0300;
                s.radii[0]     = 7'd12;
                s.radii[1]     = 7'd12;
            end
            default: begin
                s.locations[0] = 32'h0100_0000;
                s.locations[2] = 32'hff00_0000;
                s.masses[0]    = 16'h0400;
                s.masses[1]    = 16'h0400;
                s.radii[0]     = 7'd15;
                s.radii[1]     = 7'd15;
            end
        endcase
        return s;
    endfunction

    // OR of every 12-bit slice of every coordinate; the top slice is zero-extended.
    function automatic logic [ACT_W-1:0] fold(input logic [NCOORD*WIDTH-1:0] locs);
        logic [ACT_W-1:0] f;
        f = '0;
        for (int c = 0; c < NCOORD; c++) begin
            for (int b = 0; b < WIDTH; b++) begin
                f[b % ACT_W] = f[b % ACT_W] | locs[c*WIDTH + b];
            end
        end
        return f;
    endfunction
endpackage

// File: rtl/sim_controller_if.sv
// Signal bundle between sim_controller and its surroundings (buttons, VGA timing, physics engine).
interface sim_controller_if import sim_pkg::*; #(
    parameter int SCENES = 4
);
    localparam int IDX_W = (SCENES > 1) ? $clog2(SCENES) : 1;

    logic                          btn_run;
    logic                          btn_step;
    logic                          btn_scene;
    logic                          vsync;
    logic [NCOORD*WIDTH-1:0]       engine_locations;
    logic [NCOORD*WIDTH-1:0]       init_locations;
    logic [NCOORD*WIDTH-1:0]       init_velos;
    logic [SPRITES*(WIDTH/2)-1:0]  masses;
    logic [SPRITES*RADIUS_W-1:0]   radii;
    logic                          engine_rst_n;
    logic                          engine_enable;
    logic [NCOORD*WIDTH-1:0]       display_locations;
    logic [IDX_W-1:0]              scene_idx;
    logic [15:0]                   LED;

    modport master (
        input  btn_run, btn_step, btn_scene, vsync, engine_locations,
        output init_locations, init_velos, masses, radii, engine_rst_n,
               engine_enable, display_locations, scene_idx, LED
    );

    modport slave (
        output btn_run, btn_step, btn_scene, vsync, engine_locations,
        input  init_locations, init_velos, masses, radii, engine_rst_n,
               engine_enable, display_locations, scene_idx, LED
    );
endinterface

// File: rtl/sim_controller_debounce.sv
// Button synchroniser and debouncer: one-cycle press pulse after DEBOUNCE_CYCLES stable-high samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_620_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;
    logic          differ_s;
    logic          accept_s;

    // A new level is accepted once it has differed from the stable level long enough.
    always_comb begin
        differ_s = sync_r[1] ^ stable_r;
        accept_s = differ_s && (cnt_r == CNT_LAST);
    end

    // Synchroniser, stability counter and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= 2'b00;
            stable_r <= 1'b0;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], btn};
            if (!differ_s || accept_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (accept_s) begin
                stable_r <= sync_r[1];
            end
            press_r <= accept_s & sync_r[1];
        end
    end

    assign press = press_r;
endmodule

// File: rtl/sim_controller.sv
// Run/pause/step/scene sequencing for the physics engine, with per-frame location snapshot and LED status.
module sim_controller import sim_pkg::*; #(
    parameter int SCENES          = 4,
    parameter int DEBOUNCE_CYCLES = 1_620_000,
    parameter int LOAD_CYCLES     = 4
) (
    input logic              clock_162,
    input logic              rst_n,
    sim_controller_if.master bus
);
    localparam int IDX_W = (SCENES > 1) ? $clog2(SCENES) : 1;
    localparam int LW    = $clog2(LOAD_CYCLES + 1);
    localparam logic [LW-1:0]    LOAD_LAST = LW'(LOAD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SCENES - 1);

    logic                    run_press_s;
    logic                    step_press_s;
    logic                    scene_press_s;
    logic [2:0]              vsync_r;
    logic                    vsync_rise_s;
    state_t                  state_r;
    state_t                  state_n;
    logic [LW-1:0]           load_cnt_r;
    logic [LW-1:0]           load_cnt_n;
    logic [IDX_W-1:0]        scene_idx_r;
    logic [IDX_W-1:0]        scene_idx_n;
    logic                    eng_rst_n_r;
    logic                    eng_en_r;
    logic [NCOORD*WIDTH-1:0] display_r;
    logic [ACT_W-1:0]        act_r;
    logic [1:0]              led_idx_s;
    scene_t                  scene_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk(clock_162), .rst_n(rst_n), .btn(bus.btn_run), .press(run_press_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk(clock_162), .rst_n(rst_n), .btn(bus.btn_step), .press(step_press_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_scene (
        .clk(clock_162), .rst_n(rst_n), .btn(bus.btn_scene), .press(scene_press_s)
    );

    // Scene table lookup and LED field formatting.
    always_comb begin
        scene_s      = scene_rom(8'(scene_idx_r));
        led_idx_s    = 2'(scene_idx_r);
        vsync_rise_s = vsync_r[1] & ~vsync_r[2];
    end

    // Next-state logic; a scene press overrides everything and restarts the load.
    always_comb begin
        state_n     = state_r;
        load_cnt_n  = load_cnt_r;
        scene_idx_n = scene_idx_r;
        if (scene_press_s) begin
            scene_idx_n = (scene_idx_r == IDX_LAST) ? '0 : scene_idx_r + IDX_W'(1);
            state_n     = ST_LOAD;
            load_cnt_n  = '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (load_cnt_r == LOAD_LAST) begin
                        state_n    = ST_PAUSED;
                        load_cnt_n = '0;
                    end else begin
                        load_cnt_n = load_cnt_r + LW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (run_press_s) begin
                        state_n = ST_RUN;
                    end else if (step_press_s) begin
                        state_n = ST_STEP;
                    end else begin
                        state_n = ST_PAUSED;
                    end
                end
                ST_RUN: begin
                    if (run_press_s) begin
                        state_n = ST_PAUSED;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
                ST_STEP: begin
                    if (run_press_s || vsync_rise_s) begin
                        state_n = ST_PAUSED;
                    end else begin
                        state_n = ST_STEP;
                    end
                end
                default: begin
                    state_n    = ST_LOAD;
                    load_cnt_n = '0;
                end
            endcase
        end
    end

    // State, scene index and engine control registers (controls follow the next state).
    always_ff @(posedge clock_162 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOAD;
            load_cnt_r  <= '0;
            scene_idx_r <= '0;
            eng_rst_n_r <= 1'b0;
            eng_en_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            load_cnt_r  <= load_cnt_n;
            scene_idx_r <= scene_idx_n;
            eng_rst_n_r <= (state_n != ST_LOAD);
            eng_en_r    <= (state_n == ST_RUN) || (state_n == ST_STEP);
        end
    end

    // VSYNC synchroniser, frame snapshot and activity accumulator.
    always_ff @(posedge clock_162 or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r   <= 3'b000;
            display_r <= '0;
            act_r     <= '0;
        end else begin
            vsync_r <= {vsync_r[1:0], bus.vsync};
            if (vsync_rise_s) begin
                display_r <= (state_r == ST_LOAD) ? scene_s.locations : bus.engine_locations;
            end
            if (state_r == ST_LOAD) begin
                act_r <= '0;
            end else if ((state_r == ST_RUN) || (state_r == ST_STEP)) begin
                act_r <= act_r | fold(bus.engine_locations);
            end
        end
    end

    assign bus.init_locations    = scene_s.locations;
    assign bus.init_velos        = scene_s.velos;
    assign bus.masses            = scene_s.masses;
    assign bus.radii             = scene_s.radii;
    assign bus.engine_rst_n      = eng_rst_n_r;
    assign bus.engine_enable     = eng_en_r;
    assign bus.display_locations = display_r;
    assign bus.scene_idx         = scene_idx_r;
    assign bus.LED               = {state_r, led_idx_s, act_r};
endmodule

// File: tb/tb_sim_controller.sv
// Scoreboard bench for sim_controller: expected output transitions are queued by the stimulus and checked by a monitor.
module tb_sim_controller;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    localparam logic [127:0] S0_LOC = {32'h0000_0000, 32'hff00_0000, 32'h0000_0000, 32'h0100_0000};
    localparam logic [127:0] S3_LOC = {32'hffcd_c000, 32'hff9b_8000, 32'h0032_4000, 32'h0064_8000};
    localparam logic [127:0] E1     = {32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0012_3004};
    localparam logic [127:0] E2     = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
    localparam logic [127:0] E3     = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    typedef struct packed {
        logic [1:0]   st;
        logic         rn;
        logic         en;
        logic [1:0]   idx;
        logic [127:0] disp;
    } obs_t;

    obs_t exp_q[$];
    int   gap_q[$];

    sim_controller_if #(.SCENES(4)) bus ();

    sim_controller #(.SCENES(4), .DEBOUNCE_CYCLES(4), .LOAD_CYCLES(4)) dut (
        .clock_162(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    function automatic obs_t get_obs();
        obs_t o;
        o.st   = bus.LED[15:14];
        o.rn   = bus.engine_rst_n;
        o.en   = bus.engine_enable;
        o.idx  = bus.scene_idx;
        o.disp = bus.display_locations;
        return o;
    endfunction

    task automatic expect_obs(input logic [1:0] st, input logic rn, input logic en,
                              input logic [1:0] idx, input logic [127:0] disp, input int gap);
        obs_t o;
        o.st = st; o.rn = rn; o.en = en; o.idx = idx; o.disp = disp;
        exp_q.push_back(o);
        gap_q.push_back(gap);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask = {scene, step, run}
    task automatic press(input logic [2:0] mask);
        bus.btn_run   = mask[0];
        bus.btn_step  = mask[1];
        bus.btn_scene = mask[2];
        tick(8);
        bus.btn_run   = 1'b0;
        bus.btn_step  = 1'b0;
        bus.btn_scene = 1'b0;
        tick(10);
    endtask

    task automatic vsync_pulse();
        bus.vsync = 1'b1;
        tick(3);
        bus.vsync = 1'b0;
        tick(5);
    endtask

    task automatic vsync_on_load();
        int n;
        n = 0;
        while (bus.engine_rst_n && n < 40) begin
            tick(1);
            n++;
        end
        check("load_seen", {127'd0, bus.engine_rst_n}, 128'd0);
        bus.vsync = 1'b1;
        tick(3);
        bus.vsync = 1'b0;
    endtask

    // Monitor: every change of the observed outputs must match the next queued expectation.
    initial begin
        obs_t prev;
        obs_t cur;
        obs_t e;
        int   eg;
        int   last;
        prev = '0;
        last = 0;
        forever begin
            @(negedge clk);
            cur = get_obs();
            if (!rst_n) begin
                prev = cur;
                last = cyc;
            end else if (cur != prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected actual st=%0d rn=%0b en=%0b idx=%0d disp=%0h required=none",
                             cur.st, cur.rn, cur.en, cur.idx, cur.disp);
                end else begin
                    e  = exp_q.pop_front();
                    eg = gap_q.pop_front();
                    if (cur != e) begin
                        failures++;
                        $display("FAIL sb_outputs actual st=%0d rn=%0b en=%0b idx=%0d disp=%0h required st=%0d rn=%0b en=%0b idx=%0d disp=%0h",
                                 cur.st, cur.rn, cur.en, cur.idx, cur.disp, e.st, e.rn, e.en, e.idx, e.disp);
                    end
                    if (eg >= 0) begin
                        checks++;
                        if (cyc - last != eg) begin
                            failures++;
                            $display("FAIL sb_cycles actual=%0d required=%0d", cyc - last, eg);
                        end
                    end
                end
                prev = cur;
                last = cyc;
            end
        end
    end

    initial begin
        int lat;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.btn_run = 1'b0;
        bus.btn_step = 1'b0;
        bus.btn_scene = 1'b0;
        bus.vsync = 1'b0;
        bus.engine_locations = E1;
        tick(3);

        check("rst_led", bus.LED, 128'd0);
        check("rst_eng_rst_n", bus.engine_rst_n, 128'd0);
        check("rst_enable", bus.engine_enable, 128'd0);
        check("rst_display", bus.display_locations, 128'd0);
        check("rst_scene_idx", bus.scene_idx, 128'd0);

        expect_obs(2'd1, 1'b1, 1'b0, 2'd0, 128'd0, 4);
        rst_n = 1'b1;
        tick(6);
        check("load_led", bus.LED, 128'h4000);
        check("s0_locations", bus.init_locations, S0_LOC);
        check("s0_velos", bus.init_velos, 128'd0);
        check("s0_masses", bus.masses, {16'h0400, 16'h0400});
        check("s0_radii", bus.radii, {7'd15, 7'd15});

        // Bouncing run button: only the final long hold is a press.
        for (int i = 0; i < 3; i++) begin
            bus.btn_run = 1'b1; tick(2);
            bus.btn_run = 1'b0; tick(2);
        end
        expect_obs(2'd2, 1'b1, 1'b1, 2'd0, 128'd0, -1);
        bus.btn_run = 1'b1;
        lat = 0;
        while (!bus.engine_enable && lat < 20) begin
            tick(1);
            lat++;
        end
        check("run_latency", {127'd0, (bus.engine_enable && lat <= 8)}, 128'd1);
        tick(3);
        bus.btn_run = 1'b0;
        tick(10);
        check("run_activity_led", bus.LED, 128'h81a7);

        expect_obs(2'd2, 1'b1, 1'b1, 2'd0, E1, -1);
        vsync_pulse();

        // Pause, then single-step one frame.
        expect_obs(2'd1, 1'b1, 1'b0, 2'd0, E1, -1);
        press(3'b001);
        bus.engine_locations = E2;
        expect_obs(2'd3, 1'b1, 1'b1, 2'd0, E1, -1);
        press(3'b010);
        expect_obs(2'd1, 1'b1, 1'b0, 2'd0, E2, -1);
        vsync_pulse();
        check("step_enable_off", bus.engine_enable, 128'd0);
        bus.engine_locations = E3;
        expect_obs(2'd1, 1'b1, 1'b0, 2'd0, E3, -1);
        vsync_pulse();
        vsync_pulse();
        check("step_paused", {126'd0, bus.LED[15:14]}, 128'd1);

        // Walk scenes up to the last entry.
        for (int k = 1; k < 4; k++) begin
            expect_obs(2'd0, 1'b0, 1'b0, 2'(k), E3, -1);
            expect_obs(2'd1, 1'b1, 1'b0, 2'(k), E3, 4);
            press(3'b100);
        end
        check("s3_locations", bus.init_locations, S3_LOC);
        check("s3_masses", bus.masses, {16'h0300, 16'h0300});

        // Scene wrap from RUN with a VSYNC landing inside the load window.
        expect_obs(2'd2, 1'b1, 1'b1, 2'd3, E3, -1);
        press(3'b001);
        expect_obs(2'd0, 1'b0, 1'b0, 2'd0, E3, -1);
        expect_obs(2'd0, 1'b0, 1'b0, 2'd0, S0_LOC, 3);
        expect_obs(2'd1, 1'b1, 1'b0, 2'd0, S0_LOC, 1);
        fork
            press(3'b100);
            vsync_on_load();
        join
        check("wrap_led", bus.LED, 128'h4000);
        check("wrap_locations", bus.init_locations, S0_LOC);

        // Run and scene pressed together: scene wins.
        expect_obs(2'd0, 1'b0, 1'b0, 2'd1, S0_LOC, -1);
        expect_obs(2'd1, 1'b1, 1'b0, 2'd1, S0_LOC, 4);
        press(3'b101);
        check("coincide_idx", bus.scene_idx, 128'd1);

        // Asynchronous reset in the middle of a step.
        expect_obs(2'd3, 1'b1, 1'b1, 2'd1, S0_LOC, -1);
        press(3'b010);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_led", bus.LED, 128'd0);
        check("arst_eng_rst_n", bus.engine_rst_n, 128'd0);
        check("arst_enable", bus.engine_enable, 128'd0);
        check("arst_display", bus.display_locations, 128'd0);
        check("arst_scene_idx", bus.scene_idx, 128'd0);
        check("arst_locations", bus.init_locations, S0_LOC);
        tick(3);
        expect_obs(2'd1, 1'b1, 1'b0, 2'd0, 128'd0, 4);
        rst_n = 1'b1;
        tick(8);
        check("rerelease_led", bus.LED, 128'h4000);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
        check("sb_drained", exp_q.size(), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
